controlador_turno: RTL and testbench

Parametrised turn controller, successor to the fixed 9-button, 2-player move logic inside the game top level. Detects one-hot button presses, checks them against a board occupancy mask, issues a single-cycle board write, and rotates among N_JOGADORES players. Sits between the button inputs and the board/state memories; the top level feeds it occupancy and fim_jogo and shows db_estado on a 7-seg display.

---
 rtl/controlador_turno_if.sv | 32 +++
 rtl/controlador_turno.sv | 156 +++++++++++++++
 tb/tb_controlador_turno.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/controlador_turno_if.sv
// Bundled button/board/status signals for controlador_turno.
// master drives buttons and board feedback; slave is the turn controller.
interface controlador_turno_if #(
  parameter int unsigned N_CELULAS   = 9,
  parameter int unsigned N_JOGADORES = 2
);
  localparam int unsigned CW = (N_CELULAS > 1) ? $clog2(N_CELULAS) : 1;
  localparam int unsigned JW = (N_JOGADORES > 1) ? $clog2(N_JOGADORES) : 1;

  logic                 iniciar;
  logic [N_CELULAS-1:0] botoes;
  logic [N_CELULAS-1:0] ocupadas;
  logic                 fim_jogo;
  logic                 we_board;
  logic [CW-1:0]        celula;
  logic [JW-1:0]        jogador;
  logic                 jogada_invalida;
  logic                 timeout;
  logic                 esperando;
  logic                 pronto;
  logic [3:0]           db_estado;

  modport master (
    output iniciar, botoes, ocupadas, fim_jogo,
    input  we_board, celula, jogador, jogada_invalida, timeout, esperando, pronto, db_estado
  );

  modport slave (
    input  iniciar, botoes, ocupadas, fim_jogo,
    output we_board, celula, jogador, jogada_invalida, timeout, esperando, pronto, db_estado
  );
endinterface

// File: rtl/controlador_turno.sv
// Turn controller: one-hot press detection, occupancy check, board write strobe, player rotation.
// Optional per-move timeout enabled by defining CONTROLE_TIMEOUT_EN.
module controlador_turno #(
  parameter int unsigned N_CELULAS   = 9,
  parameter int unsigned N_JOGADORES = 2,
  parameter int unsigned TIMEOUT     = 50000000
) (
  input logic              clock,
  input logic              reset,
  controlador_turno_if.slave bus
);

  localparam int unsigned CW = (N_CELULAS > 1) ? $clog2(N_CELULAS) : 1;
  localparam int unsigned JW = (N_JOGADORES > 1) ? $clog2(N_JOGADORES) : 1;

  localparam logic [3:0] StInicial  = 4'h0;
  localparam logic [3:0] StPrepara  = 4'h1;
  localparam logic [3:0] StEspera   = 4'h2;
  localparam logic [3:0] StRegistra = 4'h3;
  localparam logic [3:0] StValida   = 4'h4;
  localparam logic [3:0] StEscreve  = 4'h5;
  localparam logic [3:0] StVerifica = 4'h6;
  localparam logic [3:0] StTroca    = 4'h7;
  localparam logic [3:0] StFim      = 4'hF;

  logic [3:0]           state_q, state_d;
  logic [N_CELULAS-1:0] botoes_q;
  logic [N_CELULAS-1:0] sub_q, sub_d;
  logic [CW-1:0]        cel_q, cel_d;
  logic [JW-1:0]        jog_q, jog_d;
  logic [N_CELULAS-1:0] subida;
  logic                 um_bit;
  logic [CW-1:0]        idx;
  logic                 invalida;
  logic                 expirou;

`ifdef CONTROLE_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] cnt_q, cnt_d;
`endif

  assign subida = bus.botoes & ~botoes_q;
  assign um_bit = (subida != '0) && ((subida & (subida - 1'b1)) == '0);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N_CELULAS; i++) begin
      if (sub_q[i]) idx = CW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    cel_d    = cel_q;
    jog_d    = jog_q;
    invalida = 1'b0;
    expirou  = 1'b0;
`ifdef CONTROLE_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      StInicial: if (bus.iniciar) state_d = StPrepara;
      StPrepara: begin
        jog_d   = '0;
        cel_d   = '0;
`ifdef CONTROLE_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = StEspera;
      end
      StEspera: begin
`ifdef CONTROLE_TIMEOUT_EN
        // Expiry wins over a press landing on the same cycle.
        if (cnt_q == TW'(TIMEOUT - 1)) begin
          expirou = 1'b1;
          state_d = StTroca;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (um_bit) begin
            sub_d   = subida;
            state_d = StRegistra;
          end else if (subida != '0) begin
            invalida = 1'b1;
          end
        end
`else
        if (um_bit) begin
          sub_d   = subida;
          state_d = StRegistra;
        end else if (subida != '0) begin
          invalida = 1'b1;
        end
`endif
      end
      StRegistra: begin
        cel_d   = idx;
        state_d = StValida;
      end
      StValida: begin
        if (bus.ocupadas[cel_q]) begin
          invalida = 1'b1;
          state_d  = StEspera;
        end else begin
          state_d  = StEscreve;
        end
      end
      StEscreve:  state_d = StVerifica;
      StVerifica: state_d = bus.fim_jogo ? StFim : StTroca;
      StTroca: begin
        jog_d   = (jog_q == JW'(N_JOGADORES - 1)) ? '0 : jog_q + 1'b1;
`ifdef CONTROLE_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = StEspera;
      end
      StFim:   if (bus.iniciar) state_d = StPrepara;
      default: state_d = StInicial;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StInicial;
      botoes_q <= '0;
      sub_q    <= '0;
      cel_q    <= '0;
      jog_q    <= '0;
    end else begin
      state_q  <= state_d;
      botoes_q <= bus.botoes;
      sub_q    <= sub_d;
      cel_q    <= cel_d;
      jog_q    <= jog_d;
    end
  end

`ifdef CONTROLE_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign bus.timeout = expirou;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.we_board        = (state_q == StEscreve);
  assign bus.celula          = cel_q;
  assign bus.jogador         = jog_q;
  assign bus.jogada_invalida = invalida;
  assign bus.esperando       = (state_q == StEspera);
  assign bus.pronto          = (state_q == StFim);
  assign bus.db_estado       = state_q;

endmodule

// File: tb/tb_controlador_turno.sv
// Self-checking bench for controlador_turno: directed literal checks plus a randomized run
// compared every cycle against a move-level reference model.
module tb_controlador_turno;

  localparam int unsigned NC = 9;
  localparam int unsigned NJ = 3;
  localparam int unsigned TO = 16;
`ifdef CONTROLE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  controlador_turno_if #(.N_CELULAS(NC), .N_JOGADORES(NJ)) bus ();

  controlador_turno #(.N_CELULAS(NC), .N_JOGADORES(NJ), .TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 preparing, 2 waiting, 3 move in progress, 4 game over.
  // During a move, step counts cycles since the accepted press (1..5).
  int          m_mode = 0;
  int          m_step = 0;
  int          m_cel = 0;
  int          m_pend = 0;
  int          m_jog = 0;
  int          m_cnt = 0;
  logic [NC-1:0] m_prev = '0;

  always @(negedge clock) begin
    logic [NC-1:0] sub;
    int e_we, e_inv, e_to, e_esp, e_pr, e_db;
    e_we = 0; e_inv = 0; e_to = 0; e_esp = 0; e_pr = 0; e_db = 0;
    if (!reset) begin
      chk("rst_we", int'(bus.we_board), 0);
      chk("rst_celula", int'(bus.celula), 0);
      chk("rst_jogador", int'(bus.jogador), 0);
      chk("rst_inv", int'(bus.jogada_invalida), 0);
      chk("rst_timeout", int'(bus.timeout), 0);
      chk("rst_db", int'(bus.db_estado), 0);
      m_mode = 0; m_step = 0; m_cel = 0; m_jog = 0; m_cnt = 0; m_prev = '0;
    end else begin
      int nm, ns, nc, nj, nk;
      sub = bus.botoes & ~m_prev;
      nm = m_mode; ns = m_step; nc = m_cel; nj = m_jog; nk = m_cnt;
      case (m_mode)
        0: begin e_db = 0; if (bus.iniciar) nm = 1; end
        1: begin e_db = 1; nm = 2; nj = 0; nc = 0; nk = 0; end
        2: begin
          e_db = 2; e_esp = 1;
          if (TO_EN && m_cnt == TO - 1) begin
            e_to = 1; nm = 3; ns = 5;
          end else begin
            nk = m_cnt + 1;
            if ($countones(sub) == 1) begin
              m_pend = $clog2(sub); nm = 3; ns = 1;
            end else if ($countones(sub) > 1) e_inv = 1;
          end
        end
        3: begin
          e_db = 2 + m_step;
          case (m_step)
            1: begin nc = m_pend; ns = 2; end
            2: if (bus.ocupadas[m_cel]) begin e_inv = 1; nm = 2; end else ns = 3;
            3: begin e_we = 1; ns = 4; end
            4: if (bus.fim_jogo) nm = 4; else ns = 5;
            default: begin nj = (m_jog + 1) % NJ; nk = 0; nm = 2; end
          endcase
        end
        default: begin e_db = 15; e_pr = 1; if (bus.iniciar) nm = 1; end
      endcase
      chk("we_board", int'(bus.we_board), e_we);
      chk("celula", int'(bus.celula), m_cel);
      chk("jogador", int'(bus.jogador), m_jog);
      chk("jogada_invalida", int'(bus.jogada_invalida), e_inv);
      chk("timeout", int'(bus.timeout), e_to);
      chk("esperando", int'(bus.esperando), e_esp);
      chk("pronto", int'(bus.pronto), e_pr);
      chk("db_estado", int'(bus.db_estado), e_db);
      m_mode = nm; m_step = ns; m_cel = nc; m_jog = nj; m_cnt = nk;
      m_prev = bus.botoes;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accept a move on button b from ESPERA, checking write timing and final player.
  task automatic move(input int b, input int jog_now, input int jog_next);
    logic [NC-1:0] v;
    v = '0;
    v[b] = 1'b1;
    bus.botoes = v;
    tick(); chk("lit_no_we_t1", int'(bus.we_board), 0);
    tick(); chk("lit_no_we_t2", int'(bus.we_board), 0);
    tick(); chk("lit_we_t3", int'(bus.we_board), 1);
    chk("lit_celula", int'(bus.celula), b);
    chk("lit_jog_write", int'(bus.jogador), jog_now);
    bus.botoes = '0;
    tick(); tick(); tick();
    chk("lit_esp_after", int'(bus.db_estado), 2);
    chk("lit_jog_next", int'(bus.jogador), jog_next);
  endtask

  initial begin
    bus.iniciar = 1'b0; bus.botoes = '0; bus.ocupadas = '0; bus.fim_jogo = 1'b0;
    #1;
    chk("lit_reset_db", int'(bus.db_estado), 0);
    chk("lit_reset_we", int'(bus.we_board), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    bus.iniciar = 1'b1; tick();
    chk("lit_prepara", int'(bus.db_estado), 1);
    bus.iniciar = 1'b0; tick();
    chk("lit_espera", int'(bus.esperando), 1);

    move(2, 0, 1);

    // Occupied cell rejected in VALIDA.
    bus.ocupadas = 9'b000010000; bus.botoes = 9'b000010000;
    tick(); tick();
    chk("lit_occ_inv", int'(bus.jogada_invalida), 1);
    chk("lit_occ_we", int'(bus.we_board), 0);
    tick();
    chk("lit_occ_back", int'(bus.db_estado), 2);
    chk("lit_occ_jog", int'(bus.jogador), 1);
    bus.botoes = '0; bus.ocupadas = '0; tick();

    // Two buttons on the same edge.
    bus.botoes = 9'b000000011; #1;
    chk("lit_multi_inv", int'(bus.jogada_invalida), 1);
    tick(); chk("lit_multi_stay", int'(bus.db_estado), 2);
    tick(); chk("lit_hold_noinv", int'(bus.jogada_invalida), 0);
    bus.botoes = '0; tick();
    move(0, 1, 2);
    move(5, 2, 0);

    // Game over in VERIFICA, then restart.
    bus.botoes = 9'b001000000;
    tick(); tick(); tick();
    bus.fim_jogo = 1'b1; bus.botoes = '0;
    tick(); tick();
    chk("lit_fim_pronto", int'(bus.pronto), 1);
    chk("lit_fim_db", int'(bus.db_estado), 15);
    chk("lit_fim_jog", int'(bus.jogador), 0);
    bus.fim_jogo = 1'b0; bus.iniciar = 1'b1; tick();
    bus.iniciar = 1'b0; tick();
    chk("lit_restart_db", int'(bus.db_estado), 2);
    chk("lit_restart_jog", int'(bus.jogador), 0);

    // Idle ESPERA: timeout after 16 cycles, or indefinite wait without the feature.
    repeat (TO - 1) tick();
    chk("lit_to_pulse", int'(bus.timeout), TO_EN ? 1 : 0);
    chk("lit_to_we", int'(bus.we_board), 0);
    tick(); tick();
    chk("lit_to_jog", int'(bus.jogador), TO_EN ? 1 : 0);
    chk("lit_to_db", int'(bus.db_estado), 2);

    // Reset while heading for ESCREVE.
    bus.botoes = 9'b010000000;
    tick(); tick();
    reset = 1'b0; #1;
    chk("lit_mid_rst_we", int'(bus.we_board), 0);
    chk("lit_mid_rst_db", int'(bus.db_estado), 0);
    chk("lit_mid_rst_cel", int'(bus.celula), 0);
    bus.botoes = '0;
    tick();
    reset = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      tick();
      case ($urandom_range(0, 3))
        0: bus.botoes = '0;
        1: begin bus.botoes = '0; bus.botoes[$urandom_range(0, NC - 1)] = 1'b1; end
        2: ;
        default: bus.botoes = NC'($urandom);
      endcase
      bus.ocupadas = NC'($urandom & $urandom);
      bus.fim_jogo = ($urandom_range(0, 7) == 0);
      bus.iniciar  = ($urandom_range(0, 9) == 0);
      reset        = ($urandom_range(0, 499) != 0);
    end
    reset = 1'b1;
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
